// File: rtl/switch_led_pkg.sv
// Shared constants and helpers for the switch-to-LED controller.
package switch_led_pkg;

  // Board defaults: 16-cycle debounce window, 25M-cycle blink half-period.
  localparam int DEB_CYCLES_DEF = 16;
  localparam int BLINK_DIV_DEF  = 25000000;

  // Width of a counter that must hold values 0..n-1; never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/switch_led_if.sv
// Board-side bundle of the switch-to-LED controller.
//
// Signalling: there is no valid/ready handshake on this bundle. sw and
// blink_en are levels sampled every clock (sw is asynchronous and is
// synchronised inside the controller); clear is a one-cycle command that
// acts on the edge where it is sampled high. led, sw_db and toggle_pulse are
// updated every clock; toggle_pulse is a one-cycle strobe.
interface switch_led_if #(
  parameter int N_SW = 4
) ();

  logic [N_SW-1:0] sw;
  logic            blink_en;
  logic            clear;
  logic [N_SW-1:0] led;
  logic [N_SW-1:0] sw_db;
  logic [N_SW-1:0] toggle_pulse;

  // Board / stimulus side: drives switches and commands, observes LEDs.
  modport master (
    output sw,
    output blink_en,
    output clear,
    input  led,
    input  sw_db,
    input  toggle_pulse
  );

  // Controller side.
  modport slave (
    input  sw,
    input  blink_en,
    input  clear,
    output led,
    output sw_db,
    output toggle_pulse
  );

endinterface

// File: rtl/switch_debounce.sv
// One switch channel: 2-flop synchroniser, debounce counter and a
// registered strobe on each debounced rising edge.
module switch_debounce
  import switch_led_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_i,
  output logic sw_db_o,
  output logic toggle_o
);

  localparam int              CNT_W    = cnt_width(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             db_q;
  logic             db_d;
  logic             tog_q;
  logic             tog_d;

  // Two-flop synchroniser for the asynchronous switch input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sw_i;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count consecutive cycles of disagreement; accept on the last one.
  // The counter clears at DEB_CYCLES-1, so it can never wrap.
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    tog_d = db_d & ~db_q;
  end

  // Debounce state and rising-edge strobe registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      db_q  <= 1'b0;
      tog_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      db_q  <= db_d;
      tog_q <= tog_d;
    end
  end

  assign sw_db_o  = db_q;
  assign toggle_o = tog_q;

endmodule

// File: rtl/switch_led_ctrl.sv
// Multi-channel switch-to-LED controller: per-channel debounce, toggle-on-press
// LED latches, global synchronous clear and a prescaled blink gate.
module switch_led_ctrl
  import switch_led_pkg::*;
#(
  parameter int N_SW       = 4,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int BLINK_DIV  = BLINK_DIV_DEF
) (
  input  logic         clk,
  input  logic         reset,
  switch_led_if.slave  bus
);

  localparam int               PRE_W    = cnt_width(BLINK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(BLINK_DIV - 1);

  logic [N_SW-1:0]  sw_db_w;
  logic [N_SW-1:0]  tog_w;
  logic [N_SW-1:0]  state_q;
  logic [N_SW-1:0]  state_d;
  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] pre_d;
  logic             phase_q;
  logic             phase_d;

  for (genvar i = 0; i < N_SW; i++) begin : g_chan
    switch_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
      .clk      (clk),
      .reset    (reset),
      .sw_i     (bus.sw[i]),
      .sw_db_o  (sw_db_w[i]),
      .toggle_o (tog_w[i])
    );
  end

  // LED latches: clear wins over any toggle in the same cycle.
  always_comb begin
    state_d = state_q ^ tog_w;
    if (bus.clear) begin
      state_d = '0;
    end
  end

  // Blink prescaler: idle at 0 with phase on while disabled, so a new blink
  // period always starts with a full on half-period.
  always_comb begin
    pre_d   = '0;
    phase_d = 1'b1;
    if (bus.blink_en) begin
      phase_d = phase_q;
      if (pre_q == PRE_LAST) begin
        phase_d = ~phase_q;
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end
  end

  // LED state and blink registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= '0;
      pre_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      phase_q <= phase_d;
    end
  end

  assign bus.led          = state_q & {N_SW{phase_q}};
  assign bus.sw_db        = sw_db_w;
  assign bus.toggle_pulse = tog_w;

endmodule

// File: tb/tb_switch_led_ctrl.sv
// Directed bench for switch_led_ctrl (N_SW=4, DEB_CYCLES=4, BLINK_DIV=3).
// Stimulus pushes the expected {led, sw_db, toggle_pulse} for the current
// cycle; a negedge monitor pops and compares.
module tb_switch_led_ctrl;

  localparam int N   = 4;
  localparam int W   = 3 * N;

  logic clk;
  logic reset;

  switch_led_if #(.N_SW(N)) bus ();

  switch_led_ctrl #(
    .N_SW       (N),
    .DEB_CYCLES (4),
    .BLINK_DIV  (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_compared;
  int           n_mismatched;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string nm, input logic [N-1:0] l,
                            input logic [N-1:0] d, input logic [N-1:0] t);
    exp_q.push_back({l, d, t});
    name_q.push_back(nm);
  endtask

  task automatic hold(input int n, input string nm, input logic [N-1:0] l,
                      input logic [N-1:0] d, input logic [N-1:0] t);
    repeat (n) begin
      tick();
      expect_out(nm, l, d, t);
    end
  endtask

  // Scoreboard monitor: compare every pending expectation at the falling edge.
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [W-1:0] a;
    string        nm;
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {bus.led, bus.sw_db, bus.toggle_pulse};
      n_compared++;
      if (a !== e) begin
        n_mismatched++;
        $display("FAIL %s: actual led=%b sw_db=%b tp=%b, required led=%b sw_db=%b tp=%b",
                 nm, a[3*N-1:2*N], a[2*N-1:N], a[N-1:0],
                 e[3*N-1:2*N], e[2*N-1:N], e[N-1:0]);
      end
    end
  end

  initial begin
    logic [N-1:0] l;
    n_compared   = 0;
    n_mismatched = 0;
    reset        = 1'b1;
    bus.sw       = '0;
    bus.blink_en = 1'b0;
    bus.clear    = 1'b0;

    // 1. Reset with all switches high, then release.
    #2;
    reset  = 1'b0;
    bus.sw = 4'hF;
    expect_out("rst_async", 4'h0, 4'h0, 4'h0);
    hold(2, "rst_held", 4'h0, 4'h0, 4'h0);
    reset = 1'b1;
    hold(5, "rel_wait", 4'h0, 4'h0, 4'h0);
    tick(); expect_out("rel_db", 4'h0, 4'hF, 4'hF);
    tick(); expect_out("rel_led", 4'hF, 4'hF, 4'h0);
    bus.sw = 4'h0;
    hold(5, "rel_fall_wait", 4'hF, 4'hF, 4'h0);
    tick(); expect_out("rel_fall", 4'hF, 4'h0, 4'h0);
    bus.clear = 1'b1;
    tick(); bus.clear = 1'b0;
    expect_out("rel_clear", 4'h0, 4'h0, 4'h0);

    // 2. Bounce rejection on sw[0], then a clean press and release.
    bus.sw = 4'h1; hold(3, "bounce", 4'h0, 4'h0, 4'h0);
    bus.sw = 4'h0; hold(2, "bounce", 4'h0, 4'h0, 4'h0);
    bus.sw = 4'h1; hold(3, "bounce", 4'h0, 4'h0, 4'h0);
    bus.sw = 4'h0; hold(8, "bounce", 4'h0, 4'h0, 4'h0);
    bus.sw = 4'h1; hold(5, "press0_wait", 4'h0, 4'h0, 4'h0);
    tick(); expect_out("press0_db", 4'h0, 4'h1, 4'h1);
    tick(); expect_out("press0_led", 4'h1, 4'h1, 4'h0);
    bus.sw = 4'h0; hold(5, "rel0_wait", 4'h1, 4'h1, 4'h0);
    tick(); expect_out("rel0_db", 4'h1, 4'h0, 4'h0);
    hold(1, "rel0_nopulse", 4'h1, 4'h0, 4'h0);

    // 3. Three press/release cycles on sw[2].
    l = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      bus.sw = 4'b0100;
      hold(5, "tog2_wait", l, 4'b0000, 4'b0000);
      tick(); expect_out("tog2_pulse", l, 4'b0100, 4'b0100);
      l = l ^ 4'b0100;
      tick(); expect_out("tog2_led", l, 4'b0100, 4'b0000);
      bus.sw = 4'b0000;
      hold(5, "tog2_hold", l, 4'b0100, 4'b0000);
      tick(); expect_out("tog2_release", l, 4'b0000, 4'b0000);
    end

    // 4. Clear versus toggle.
    bus.clear = 1'b1;
    tick(); bus.clear = 1'b0;
    expect_out("clr_init", 4'b0000, 4'b0000, 4'b0000);
    bus.sw = 4'b0011;
    hold(5, "set01_wait", 4'b0000, 4'b0000, 4'b0000);
    tick(); expect_out("set01_pulse", 4'b0000, 4'b0011, 4'b0011);
    tick(); expect_out("set01_led", 4'b0011, 4'b0011, 4'b0000);
    bus.sw = 4'b0000;
    hold(5, "set01_hold", 4'b0011, 4'b0011, 4'b0000);
    tick(); expect_out("set01_rel", 4'b0011, 4'b0000, 4'b0000);
    bus.sw = 4'b0010;
    hold(5, "clrtog_wait", 4'b0011, 4'b0000, 4'b0000);
    tick(); expect_out("clrtog_pulse", 4'b0011, 4'b0010, 4'b0010);
    bus.clear = 1'b1;
    tick(); bus.clear = 1'b0;
    expect_out("clr_vs_tog", 4'b0000, 4'b0010, 4'b0000);
    bus.sw = 4'b1010;
    hold(5, "set3_wait", 4'b0000, 4'b0010, 4'b0000);
    tick(); expect_out("set3_pulse", 4'b0000, 4'b1010, 4'b1000);
    tick(); expect_out("set3_led", 4'b1000, 4'b1010, 4'b0000);
    bus.clear = 1'b1;
    tick(); bus.clear = 1'b0;
    expect_out("clr_keep_db", 4'b0000, 4'b1010, 4'b0000);
    bus.sw = 4'b0000;
    hold(5, "set3_hold", 4'b0000, 4'b1010, 4'b0000);
    tick(); expect_out("set3_rel", 4'b0000, 4'b0000, 4'b0000);

    // 5. Blink with state 1010.
    bus.sw = 4'b1010;
    hold(5, "bl_set_wait", 4'b0000, 4'b0000, 4'b0000);
    tick(); expect_out("bl_set_pulse", 4'b0000, 4'b1010, 4'b1010);
    tick(); expect_out("bl_set_led", 4'b1010, 4'b1010, 4'b0000);
    bus.sw = 4'b0000;
    hold(5, "bl_set_hold", 4'b1010, 4'b1010, 4'b0000);
    tick(); expect_out("bl_set_rel", 4'b1010, 4'b0000, 4'b0000);
    bus.blink_en = 1'b1;
    expect_out("blink_on0", 4'b1010, 4'b0000, 4'b0000);
    hold(2, "blink_on1", 4'b1010, 4'b0000, 4'b0000);
    hold(3, "blink_off1", 4'b0000, 4'b0000, 4'b0000);
    hold(3, "blink_on2", 4'b1010, 4'b0000, 4'b0000);
    hold(2, "blink_off2", 4'b0000, 4'b0000, 4'b0000);
    bus.blink_en = 1'b0;
    tick(); expect_out("blink_stop", 4'b1010, 4'b0000, 4'b0000);
    hold(2, "blink_idle", 4'b1010, 4'b0000, 4'b0000);

    // 6. Reset during a debounce count and a blink off phase.
    bus.blink_en = 1'b1;
    bus.sw       = 4'b0001;
    expect_out("mid_on0", 4'b1010, 4'b0000, 4'b0000);
    hold(2, "mid_on", 4'b1010, 4'b0000, 4'b0000);
    hold(2, "mid_off", 4'b0000, 4'b0000, 4'b0000);
    reset = 1'b0;
    expect_out("mid_rst_async", 4'b0000, 4'b0000, 4'b0000);
    hold(1, "mid_rst_held", 4'b0000, 4'b0000, 4'b0000);
    reset = 1'b1;
    hold(5, "mid_rel_wait", 4'b0000, 4'b0000, 4'b0000);
    tick(); expect_out("mid_rel_pulse", 4'b0000, 4'b0001, 4'b0001);
    tick(); expect_out("mid_rel_on_a", 4'b0001, 4'b0001, 4'b0000);
    tick(); expect_out("mid_rel_on_b", 4'b0001, 4'b0001, 4'b0000);
    tick(); expect_out("mid_rel_off", 4'b0000, 4'b0001, 4'b0000);
    bus.blink_en = 1'b0;
    tick(); expect_out("mid_rel_stop", 4'b0001, 4'b0001, 4'b0000);

    // Drain and report.
    @(negedge clk);
    #1;
    n_compared++;
    if (exp_q.size() != 0) begin
      n_mismatched++;
      $display("FAIL drain: actual pending=%0d required pending=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/switch_led_ctrl.md
Name: switch_led_ctrl

Overview:
Multi-channel switch-to-LED controller for the board's slide switches and LED bank. Each switch input is synchronised and debounced. A debounced rising edge toggles that channel's latched LED state. A global blink mode gates all lit LEDs with a prescaled square wave, and a synchronous clear turns every LED off.

Parameters:
N_SW, 4, number of switch/LED channels (1..16)
DEB_CYCLES, 16, consecutive cycles a synchronised switch must differ from its debounced value before the change is accepted (>=2)
BLINK_DIV, 25000000, blink half-period in clk cycles (>=2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
sw  in  N_SW  raw switch inputs, asynchronous to clk
blink_en  in  1  level; 1 = blink gating enabled
clear  in  1  synchronous one-cycle command; forces all LED states to 0
led  out  N_SW  LED drive, 1 = on
sw_db  out  N_SW  debounced switch levels
toggle_pulse  out  N_SW  one-cycle strobe per debounced rising edge

Behaviour:
- Reset: clk and an asynchronous, active-low reset; assertion immediately clears all state, release is synchronous to clk.
- Reset values: synchroniser flops 0, debounce counters 0, sw_db 0, toggle_pulse 0, LED state 0, prescaler 0, blink phase 1; led = 0.
- Synchroniser: 2-flop chain per bit, producing sw_s.
- Debounce, per bit:
  - if sw_s == sw_db, the counter clears;
  - otherwise the counter increments;
  - when the counter equals DEB_CYCLES-1 and sw_s still differs, sw_db takes sw_s on that edge and the counter clears.
- Debounce consequences:
  - a change on sw that is held steady reaches sw_db 2+DEB_CYCLES edges later;
  - any pulse on sw_s shorter than DEB_CYCLES cycles produces no sw_db change.
- Counter width: $clog2(DEB_CYCLES); no wrap is possible because the counter clears at DEB_CYCLES-1.
- toggle_pulse[i]: registered; high for exactly the one cycle in which sw_db[i] first reads 1 after reading 0. Falling edges produce no pulse.
- LED state[i]: inverts on the clk edge where toggle_pulse[i] = 1, i.e. one cycle after the pulse is visible.
- Simultaneous events: clear has priority over toggle in the same cycle (state -> 0). Independent channels may toggle in the same cycle.
- Blink prescaler:
  - while blink_en = 0, prescaler is held at 0 and phase at 1;
  - while blink_en = 1, the prescaler counts 0..BLINK_DIV-1; on the wrap edge it returns to 0 and phase inverts.
  - Width is $clog2(BLINK_DIV).
- led = state & {N_SW{phase}}. This is combinational from registers, so there is no extra latency; blink_en = 0 therefore yields led = state.
- Blink start: when blink_en rises, LEDs stay on (phase 1) for BLINK_DIV cycles, then go off for BLINK_DIV cycles, and so on.
- Blink stop: deasserting blink_en mid-period restores led = state on the next edge.
- clear does not affect sw_db, the debounce counters, or the blink prescaler.
- Reset asserted mid-debounce or mid-blink: everything returns to reset values. A switch held high through reset release produces a toggle 2+DEB_CYCLES cycles after release (LED then turns on).

Decomposition:
- Shared package switch_led_pkg holds:
  - default constants DEB_CYCLES_DEF and BLINK_DIV_DEF;
  - the counter-width function (clog2 wrapper).
- One natural sub-module: switch_debounce, a single-bit synchroniser, debounce counter and rising-edge strobe. Outputs: sw_db bit and toggle_pulse bit.
- switch_led_ctrl instantiates N_SW copies in a generate loop and holds the LED state, clear logic and blink prescaler.

Test Plan:
Bench parameters are N_SW=4, DEB_CYCLES=4, BLINK_DIV=3.
1. Reset: reset=0 with sw=4'hF, then release. -> All outputs 0 during reset. sw_db=4'hF six cycles after release, toggle_pulse=4'hF for one cycle, led=4'hF on the next cycle.
2. Bounce rejection: sw[0] high for 3 cycles, low for 2, high for 3, then low. -> sw_db[0] stays 0, no toggle_pulse, led=0. Holding sw[0] high for 4 or more cycles gives sw_db[0]=1 at cycle 6 and led[0]=1 at cycle 7.
3. Toggle sequence: three debounced press/release cycles on sw[2]. -> Exactly three toggle_pulse[2] strobes, led[2] goes 1, then 0, then 1. No pulse on release.
4. Clear vs toggle: clear asserted in the same cycle as toggle_pulse[1], with led=4'b0011 beforehand. -> led=4'b0000. A later clear with no toggle also gives 0, and sw_db is unchanged.
5. Blink: led state 4'b1010, then blink_en=1. -> led=1010 for 3 cycles, 0000 for 3, 1010 for 3. Deasserting blink_en during an off phase gives led=1010 on the next cycle.
6. Mid-operation reset: reset pulsed low during a debounce count and a blink off phase. -> Outputs 0 immediately. After release, phase=1 and counters restart from 0.
